// File: rtl/ts_pkg.sv
// Shared definitions for the TS word-stream checker: header field positions,
// FSM encoding, error-flag bit indices and header field extractors.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    localparam int SYNC_MSB    = 31;
    localparam int SYNC_LSB    = 24;
    localparam int PID_MSB     = 20;
    localparam int PID_LSB     = 8;
    localparam int AFC_PAY_BIT = 4;
    localparam int CC_MSB      = 3;
    localparam int CC_LSB      = 0;

    localparam int ERR_W     = 5;
    localparam int ERR_STRAY = 4;
    localparam int ERR_LEN   = 3;
    localparam int ERR_SYNC  = 2;
    localparam int ERR_PID   = 1;
    localparam int ERR_CC    = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } ts_state_e;

    function automatic logic [7:0] hdr_sync(input logic [31:0] w);
        return w[SYNC_MSB:SYNC_LSB];
    endfunction

    function automatic logic [12:0] hdr_pid(input logic [31:0] w);
        return w[PID_MSB:PID_LSB];
    endfunction

    // AFC bit 0 set means the packet carries payload, so CC must advance.
    function automatic logic hdr_payload(input logic [31:0] w);
        return w[AFC_PAY_BIT];
    endfunction

    function automatic logic [3:0] hdr_cc(input logic [31:0] w);
        return w[CC_MSB:CC_LSB];
    endfunction

endpackage

// File: rtl/ts_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module ts_sat_cnt32 (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ts_chk32.sv
// Receive-side checker for the 32-bit TS word stream: framing, sync byte,
// PID and continuity-counter sequencing, with per-packet status and counters.
module ts_chk32
    import ts_pkg::*;
#(
    parameter int          PKT_WORDS = 48,
    parameter int          HDR_WORD  = 2,
    parameter logic [7:0]  SYNC_BYTE = TS_SYNC_BYTE,
    parameter logic [12:0] EXP_PID   = 13'h0014,
    parameter bit          PID_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ts_sync,
    input  logic        ts_valid,
    input  logic        ts_eop,
    input  logic [31:0] ts_data,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [4:0]  err_flags,
    output logic [12:0] last_pid,
    output logic [3:0]  last_cc,
    output logic        cc_lock,
    output logic [31:0] pkt_cnt,
    output logic [31:0] err_cnt
);

    localparam int              CW       = $clog2(PKT_WORDS + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(PKT_WORDS);
    localparam logic [CW-1:0]   HDR_IDX  = CW'(HDR_WORD);
    localparam logic [ERR_W-1:0] LOCK_KILL = ~(ERR_W'(1) << ERR_PID);

    // Stream protocol: a word exists only when ts_valid=1; ts_sync and ts_eop
    // are qualified by ts_valid. There is no backpressure.
    ts_state_e        state_q, state_d;
    logic [CW-1:0]    word_cnt_q, word_cnt_d;
    logic [ERR_W-1:0] acc_q, acc_d;
    logic             hdr_seen_q, hdr_seen_d;
    logic             stray_rep_q, stray_rep_d;
    logic             cc_lock_q, cc_lock_d;
    logic [12:0]      last_pid_q, last_pid_d;
    logic [3:0]       last_cc_q, last_cc_d;
    logic             pkt_done_q, pkt_done_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic [ERR_W-1:0] err_flags_q, err_flags_d;

    logic             fin;
    logic [ERR_W-1:0] fin_flags;
    logic [CW-1:0]    cur_cnt;
    logic [ERR_W-1:0] cur_flags;
    logic             cur_hdr;
    logic [3:0]       cc_exp;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        acc_d       = acc_q;
        hdr_seen_d  = hdr_seen_q;
        stray_rep_d = stray_rep_q;
        cc_lock_d   = cc_lock_q;
        last_pid_d  = last_pid_q;
        last_cc_d   = last_cc_q;
        fin         = 1'b0;
        fin_flags   = '0;
        cur_cnt     = '0;
        cur_flags   = '0;
        cur_hdr     = 1'b0;
        cc_exp      = last_cc_q;

        // A sync inside a packet closes the old packet as a length error.
        if (ts_valid && ts_sync && (state_q == ST_PKT)) begin
            fin                 = 1'b1;
            fin_flags           = acc_q;
            fin_flags[ERR_LEN]  = 1'b1;
            if (!hdr_seen_q) begin
                fin_flags[ERR_SYNC] = 1'b1;
            end
        end

        if (ts_valid && !ts_sync && (state_q == ST_IDLE)) begin
            if (!stray_rep_q) begin
                fin                  = 1'b1;
                fin_flags[ERR_STRAY] = 1'b1;
                stray_rep_d          = 1'b1;
            end
            if (ts_eop) begin
                stray_rep_d = 1'b0;
            end
        end

        if (ts_valid && (ts_sync || (state_q == ST_PKT))) begin
            stray_rep_d = 1'b0;
            cur_cnt     = ts_sync ? CW'(1) : (word_cnt_q + 1'b1);
            cur_flags   = ts_sync ? '0 : acc_q;
            cur_hdr     = ts_sync ? 1'b0 : hdr_seen_q;

            if (cur_cnt == HDR_IDX) begin
                cc_exp = hdr_payload(ts_data) ? (last_cc_q + 4'd1) : last_cc_q;
                if (hdr_sync(ts_data) != SYNC_BYTE) begin
                    cur_flags[ERR_SYNC] = 1'b1;
                end
                if (PID_CHECK && (hdr_pid(ts_data) != EXP_PID)) begin
                    cur_flags[ERR_PID] = 1'b1;
                end
                if (cc_lock_q && (hdr_cc(ts_data) != cc_exp)) begin
                    cur_flags[ERR_CC] = 1'b1;
                end
                last_pid_d = hdr_pid(ts_data);
                last_cc_d  = hdr_cc(ts_data);
                cc_lock_d  = 1'b1;
                cur_hdr    = 1'b1;
            end

            if (ts_eop || (cur_cnt == LAST_IDX)) begin
                if (ts_eop != (cur_cnt == LAST_IDX)) begin
                    cur_flags[ERR_LEN] = 1'b1;
                end
                if (!cur_hdr) begin
                    cur_flags[ERR_SYNC] = 1'b1;
                end
                fin        = 1'b1;
                fin_flags  = fin_flags | cur_flags;
                state_d    = ST_IDLE;
                word_cnt_d = '0;
                acc_d      = '0;
                hdr_seen_d = 1'b0;
            end else begin
                state_d    = ST_PKT;
                word_cnt_d = cur_cnt;
                acc_d      = cur_flags;
                hdr_seen_d = cur_hdr;
            end
        end

        // Only a PID mismatch keeps the CC reference; anything else re-acquires.
        if (fin && ((fin_flags & LOCK_KILL) != '0)) begin
            cc_lock_d = 1'b0;
        end

        pkt_done_d  = fin;
        pkt_ok_d    = fin ? (fin_flags == '0) : pkt_ok_q;
        err_flags_d = fin ? fin_flags : err_flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            acc_q       <= '0;
            hdr_seen_q  <= 1'b0;
            stray_rep_q <= 1'b0;
            cc_lock_q   <= 1'b0;
            last_pid_q  <= '0;
            last_cc_q   <= '0;
            pkt_done_q  <= 1'b0;
            pkt_ok_q    <= 1'b0;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            acc_q       <= acc_d;
            hdr_seen_q  <= hdr_seen_d;
            stray_rep_q <= stray_rep_d;
            cc_lock_q   <= cc_lock_d;
            last_pid_q  <= last_pid_d;
            last_cc_q   <= last_cc_d;
            pkt_done_q  <= pkt_done_d;
            pkt_ok_q    <= pkt_ok_d;
            err_flags_q <= err_flags_d;
        end
    end

    ts_sat_cnt32 u_pkt_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (fin && (fin_flags == '0)),
        .cnt_o (pkt_cnt)
    );

    ts_sat_cnt32 u_err_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (fin && (fin_flags != '0)),
        .cnt_o (err_cnt)
    );

    assign pkt_done  = pkt_done_q;
    assign pkt_ok    = pkt_ok_q;
    assign err_flags = err_flags_q;
    assign last_pid  = last_pid_q;
    assign last_cc   = last_cc_q;
    assign cc_lock   = cc_lock_q;

endmodule

// File: doc/ts_chk32.md
Name: ts_chk32

Overview:
- Receive-side checker for the 32-bit TS word stream (ts_sync / ts_valid / ts_eop / ts_data) produced by the bench TS generator and by the out_board TS datapath.
- Checks packet framing, the 0x47 sync byte, the PID and continuity-counter sequencing.
- Reports a per-packet status pulse and running packet/error counters; used as the scoreboard end of the test bench and as an optional on-board monitor.

Parameters:
- U_DLY, 1, register assignment delay (ns), simulation only
- PKT_WORDS, 48, words per packet, sync word through eop word inclusive
- HDR_WORD, 2, 1-based index of the TS header word within the packet
- SYNC_BYTE, 8'h47, required value of header bits [31:24]
- EXP_PID, 13'h0014, expected PID
- PID_CHECK, 1, 1 = PID mismatch is an error; 0 = PID only captured

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- ts_sync  input  1  first word of packet, qualified by ts_valid
- ts_valid  input  1  word valid
- ts_eop  input  1  last word of packet, qualified by ts_valid
- ts_data  input  32  packet word
- pkt_done  output  1  one-cycle pulse: a packet check finished (good or bad)
- pkt_ok  output  1  status of the packet reported by pkt_done; held until the next pkt_done
- err_flags  output  5  {err_stray, err_len, err_sync, err_pid, err_cc}; held with pkt_ok
- last_pid  output  13  PID of the last header word captured
- last_cc  output  4  CC of the last header word captured
- cc_lock  output  1  1 = a CC reference exists
- pkt_cnt  output  32  packets with pkt_ok=1, saturating
- err_cnt  output  32  packets with pkt_ok=0 plus stray events, saturating

Behaviour:
- Synchronous logic only, all in the clk domain. rst=1 forces:
  - FSM to IDLE
  - all outputs to 0 (pkt_done, pkt_ok, err_flags, last_pid, last_cc, cc_lock, pkt_cnt, err_cnt)
  - the word counter to 0
- Only cycles with ts_valid=1 are words. ts_valid=0 cycles inside a packet are stalls: no count, no error.
- Header field layout:
  - [31:24] sync
  - [23] TEI, [22] PUSI, [21] priority
  - [20:8] PID
  - [7:6] scrambling, [5:4] AFC
  - [3:0] CC
- FSM states: IDLE, PKT.
- IDLE:
  - valid & sync → word_cnt=1 → PKT (if eop is also set, handle as in PKT).
  - valid & !sync → stray word: err_stray pulse. pkt_done=1, pkt_ok=0, err_cnt+1, once per stray run (the first stray word after IDLE entry).
- PKT, per valid word, word_cnt increments (word_cnt = index of the current word):
  - Word HDR_WORD:
    - data[31:24]≠SYNC_BYTE → err_sync.
    - PID≠EXP_PID with PID_CHECK=1 → err_pid.
    - Capture last_pid and last_cc.
  - CC rule, when cc_lock=1:
    - AFC[0]=1 (payload present): expected CC = last_cc+1 mod 16 (F→0 is legal).
    - AFC[0]=0: expected CC = last_cc (no increment).
    - Mismatch → err_cc.
  - cc_lock=0: no CC check. cc_lock is set when the header word is captured.
  - eop with word_cnt==PKT_WORDS → finish, → IDLE.
  - eop with word_cnt≠PKT_WORDS → err_len, finish, → IDLE.
  - word_cnt reaches PKT_WORDS without eop → err_len, finish. Later words up to and including eop are treated as stray (err_stray reported once).
  - valid & sync inside PKT → err_len for the current packet (finish) and, in the same cycle, start a new packet with word_cnt=1.
  - Packet ends before HDR_WORD → err_sync also set; no header is captured.
- Finish:
  - On the cycle after the terminating word: pkt_done=1, pkt_ok = no error flag set, err_flags latched.
  - pkt_ok=1 → pkt_cnt+1; pkt_ok=0 → err_cnt+1.
  - Any error other than err_pid clears cc_lock, so the next header re-acquires the CC reference.
- Latency: pkt_done exactly 1 clk after the eop word (or after the aborting sync/stray word).
- A stray event and a packet finish in the same cycle: one pkt_done; err_flags are the OR of both; err_cnt increments by 1.
- Counters saturate at 32'hFFFF_FFFF; they never wrap.
- rst mid-packet: the packet is discarded with no pkt_done. The next packet starts with cc_lock=0.

Decomposition:
- Shared package ts_pkg:
  - header field bit positions (sync, PID, AFC, CC)
  - TS_SYNC_BYTE = 8'h47
  - FSM state encodings
  - err_flags bit indices
- Sub-module ts_sat_cnt32:
  - saturating 32-bit counter with inc and sync clear
  - instantiated twice, for pkt_cnt and err_cnt

Test Plan:
- Generator-format packets, 48 words, header {8'h47,16'h0014,4'h1,cc}, cc 0..F then 0, gap 100 clk → 17 pkt_done pulses, all pkt_ok=1, pkt_cnt=17, err_cnt=0, last_cc=4'h0; no CC error at the F→0 wrap.
- Third packet CC skips from 2 to 4 → that packet err_flags=5'b00001, err_cnt=1, cc_lock=0. The next packet (CC=5) reports pkt_ok=1 as the re-lock packet; the packet after that (CC=6) reports pkt_ok=1.
- eop asserted on word 40 → err_len, pkt_done 1 clk after word 40. eop on word 48 with ts_valid toggling every other cycle → pkt_ok=1.
- Header sync byte 8'h46 → err_sync. PID 13'h0015 with PID_CHECK=1 → err_pid only, cc_lock stays 1. Same PID with PID_CHECK=0 → pkt_ok=1, last_pid=13'h0015.
- 3 valid words without sync in IDLE → exactly one pkt_done with err_stray, err_cnt+1. A sync arriving at word 20 of a packet → err_len for the old packet, and the new packet completes with pkt_ok=1.
- rst held 1 clk at word 30 → no pkt_done, all outputs 0. Preload err_cnt near max (force 32'hFFFF_FFFE), 3 bad packets → err_cnt=32'hFFFF_FFFF.
